jt900h_ramsrv: RTL and testbench

JT900H_RAMSRV -- requirements
Module: jt900h_ramsrv

---
 rtl/jt900h_ramsrv.sv | 166 ++++++++++++++++
 tb/tb_jt900h_ramsrv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_ramsrv.sv
// 16-bit CPU word port served from an 8-bit external memory, with a one-entry write buffer and a one-word read tag.
// Optional macro JT900H_RAMSRV_WRFWD_EN: writes to the tagged word update ram_dout directly instead of forcing a reread.
module jt900h_ramsrv #(
  parameter int unsigned WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [23:0] ram_addr,
  input  logic [15:0] ram_din,
  input  logic [1:0]  ram_we,
  output logic [15:0] ram_dout,
  output logic        ram_ok,
  output logic [23:0] ext_addr,
  input  logic [7:0]  ext_din,
  output logic [7:0]  ext_dout,
  output logic        ext_cs,
  output logic        ext_we,
  output logic        wr_err
);

  localparam int unsigned WW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] tag;
  logic          tag_valid;
  logic [WW-1:0] rd_word;
  logic          rd_stale;
  logic [WW-1:0] wb_word;
  logic [DW-1:0] wb_data;
  logic [1:0]    wb_mask;
  logic          wb_valid;

  logic [WW-1:0] cpu_word;
  logic          cap;
  logic          last;
  logic          hit;
  logic          rd_hit_wr;
  logic          unused_addr0;

  assign cpu_word     = ram_addr[23:1];
  assign cap          = ram_we != 2'b00;
  assign last         = cnt == CW'(WAIT);
  assign hit          = tag_valid && (tag == cpu_word);
  assign unused_addr0 = ram_addr[0];
  // a write accepted this cycle into the word currently being fetched makes that fetch stale
  assign rd_hit_wr    = cap && !wb_valid && (cpu_word == rd_word) &&
                        ((state == RD_LO) || (state == RD_HI));
  assign ram_ok       = hit && !wb_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      rd_word   <= '0;
      rd_stale  <= 1'b0;
      wb_word   <= '0;
      wb_data   <= '0;
      wb_mask   <= '0;
      wb_valid  <= 1'b0;
      ram_dout  <= '0;
      ext_addr  <= '0;
      ext_dout  <= '0;
      ext_cs    <= 1'b0;
      ext_we    <= 1'b0;
      wr_err    <= 1'b0;
    end else if (cen) begin
      // write capture; a second write while one is pending is dropped
      if (cap) begin
        if (wb_valid) begin
          wr_err <= 1'b1;
        end else begin
          wb_valid <= 1'b1;
          wb_word  <= cpu_word;
          wb_data  <= ram_din;
          wb_mask  <= ram_we;
          if (hit) begin
`ifdef JT900H_RAMSRV_WRFWD_EN
            if (ram_we[0]) ram_dout[7:0]  <= ram_din[7:0];
            if (ram_we[1]) ram_dout[15:8] <= ram_din[15:8];
`else
            tag_valid <= 1'b0;
`endif
          end
          if (rd_hit_wr) rd_stale <= 1'b1;
        end
      end

      if (state != IDLE) cnt <= last ? '0 : cnt + CW'(1);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (wb_valid) begin
            if (wb_mask[0]) begin
              state    <= WR_LO;
              ext_addr <= {wb_word, 1'b0};
              ext_dout <= wb_data[7:0];
            end else begin
              state    <= WR_HI;
              ext_addr <= {wb_word, 1'b1};
              ext_dout <= wb_data[15:8];
            end
            ext_cs <= 1'b1;
            ext_we <= 1'b1;
          end else if (!cap && !hit) begin
            state     <= RD_LO;
            rd_word   <= cpu_word;
            rd_stale  <= 1'b0;
            tag_valid <= 1'b0;
            ext_addr  <= {cpu_word, 1'b0};
            ext_cs    <= 1'b1;
            ext_we    <= 1'b0;
          end
        end
        RD_LO: begin
          if (last) begin
            ram_dout[7:0] <= ext_din;
            state         <= RD_HI;
            ext_addr      <= {rd_word, 1'b1};
          end
        end
        RD_HI: begin
          if (last) begin
            ram_dout[15:8] <= ext_din;
            tag            <= rd_word;
            tag_valid      <= !(rd_stale || rd_hit_wr);
            state          <= IDLE;
            ext_cs         <= 1'b0;
          end
        end
        WR_LO: begin
          if (last) begin
            if (wb_mask[1]) begin
              state    <= WR_HI;
              ext_addr <= {wb_word, 1'b1};
              ext_dout <= wb_data[15:8];
            end else begin
              state    <= IDLE;
              wb_valid <= 1'b0;
              ext_cs   <= 1'b0;
              ext_we   <= 1'b0;
            end
          end
        end
        WR_HI: begin
          if (last) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            ext_cs   <= 1'b0;
            ext_we   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_ramsrv.sv
// Self-checking bench: three instances (WAIT 0/2/3) share CPU stimulus, each with its own external byte memory.
module tb_jt900h_ramsrv;

  localparam int NI = 3;
  localparam int WAITS [NI] = '{0, 2, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_we;
  logic [15:0] ram_dout [NI];
  logic        ram_ok   [NI];
  logic [23:0] ext_addr [NI];
  logic [7:0]  ext_din  [NI];
  logic [7:0]  ext_dout [NI];
  logic        ext_cs   [NI];
  logic        ext_we   [NI];
  logic        wr_err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    jt900h_ramsrv #(.WAIT(WAITS[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout[g]),
      .ram_ok   (ram_ok[g]),
      .ext_addr (ext_addr[g]),
      .ext_din  (ext_din[g]),
      .ext_dout (ext_dout[g]),
      .ext_cs   (ext_cs[g]),
      .ext_we   (ext_we[g]),
      .wr_err   (wr_err[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // initial external memory contents
  function automatic logic [7:0] def_byte(input logic [23:0] a);
    case (a)
      24'h001000: return 8'h34;
      24'h001001: return 8'h12;
      24'h003000: return 8'h66;
      24'h003001: return 8'h55;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC3;
    endcase
  endfunction

  logic [7:0] mem [logic [25:0]];
  int rd_cnt [NI];
  int wr_lo_cnt [NI];
  int wr_hi_cnt [NI];
  logic [23:0] wr_last_addr [NI];

  function automatic logic [7:0] mem_rd(input int g, input logic [23:0] a);
    logic [25:0] k;
    k = {2'(g), a};
    if (mem.exists(k)) return mem[k];
    return def_byte(a);
  endfunction

  initial begin
    for (int g = 0; g < NI; g++) begin
      rd_cnt[g] = 0; wr_lo_cnt[g] = 0; wr_hi_cnt[g] = 0; wr_last_addr[g] = '0; ext_din[g] = '0;
    end
  end

  // external memory: stores write strobes, presents read data half a cycle ahead of the sampling edge
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst_n && cen && ext_cs[g]) begin
        if (ext_we[g]) begin
          mem[{2'(g), ext_addr[g]}] = ext_dout[g];
          wr_last_addr[g] = ext_addr[g];
          if (ext_addr[g][0]) wr_hi_cnt[g]++;
          else wr_lo_cnt[g]++;
        end else begin
          rd_cnt[g]++;
        end
      end
      ext_din[g] = mem_rd(g, ext_addr[g]);
    end
  end

  // reference model: what the CPU has successfully written
  logic [7:0] gold [logic [23:0]];

  function automatic logic [7:0] gold_byte(input logic [23:0] a);
    if (gold.exists(a)) return gold[a];
    return def_byte(a);
  endfunction

  function automatic logic [15:0] gold_word(input logic [23:0] a);
    return {gold_byte({a[23:1], 1'b1}), gold_byte({a[23:1], 1'b0})};
  endfunction

  task automatic apply_write(input logic [23:0] a, input logic [15:0] d, input logic [1:0] m);
    if (m[0]) gold[{a[23:1], 1'b0}] = d[7:0];
    if (m[1]) gold[{a[23:1], 1'b1}] = d[15:8];
  endtask

  int cen_mode = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = ($urandom_range(0, 3) != 0);
      default: cen = 1'b0;
    endcase
  endtask

  task automatic pulse_wr(input logic [23:0] a, input logic [15:0] d, input logic [1:0] m);
    ram_addr = a; ram_din = d; ram_we = m; cen = 1'b1;
    tick();
    ram_we = 2'b00;
  endtask

  int lat [NI];

  task automatic wait_ok(input string tag);
    int done;
    done = 0;
    for (int g = 0; g < NI; g++) lat[g] = -1;
    for (int t = 1; t <= 400 && done < NI; t++) begin
      tick();
      done = 0;
      for (int g = 0; g < NI; g++) begin
        if (lat[g] < 0 && ram_ok[g]) lat[g] = t;
        if (lat[g] >= 0) done++;
      end
    end
    for (int g = 0; g < NI; g++)
      if (lat[g] < 0) check($sformatf("%s_timeout_i%0d", tag, g), 64'(ram_ok[g]), 64'd1);
  endtask

  task automatic check_dout(input string tag, input logic [23:0] a);
    for (int g = 0; g < NI; g++)
      check($sformatf("%s_dout_i%0d", tag, g), 64'(ram_dout[g]), 64'(gold_word(a)));
  endtask

  int snap_rd [NI];
  int snap_lo [NI];
  int snap_hi [NI];

  task automatic snap();
    for (int g = 0; g < NI; g++) begin
      snap_rd[g] = rd_cnt[g]; snap_lo[g] = wr_lo_cnt[g]; snap_hi[g] = wr_hi_cnt[g];
    end
  endtask

  initial begin
    logic [23:0] a, a1;
    logic [15:0] d;
    logic [1:0]  m;

    rst_n = 1'b0; cen = 1'b1; ram_addr = 24'h001000; ram_din = '0; ram_we = '0;

    // reset values
    tick(); tick();
    for (int g = 0; g < NI; g++)
      check($sformatf("reset_i%0d", g),
            64'({ram_dout[g], ram_ok[g], ext_addr[g], ext_dout[g], ext_cs[g], ext_we[g], wr_err[g]}), 64'd0);

    // read latency and data, cen held high
    snap();
    rst_n = 1'b1;
    wait_ok("rd1000");
    check_dout("rd1000", 24'h001000);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rd1000_lat_i%0d", g), 64'(lat[g]), 64'(2 * (WAITS[g] + 1) + 1));
      check($sformatf("rd1000_phases_i%0d", g), 64'(rd_cnt[g] - snap_rd[g]), 64'(2 * (WAITS[g] + 1)));
    end

    // cen low freezes everything
    cen_mode = 2;
    tick();
    ram_addr = 24'h003000;
    for (int i = 0; i < 5; i++) tick();
    for (int g = 0; g < NI; g++)
      check($sformatf("cen_hold_i%0d", g),
            64'({ram_ok[g], ext_cs[g], ext_addr[g], ram_dout[g]}), 64'({1'b0, 1'b0, 24'h001001, 16'h1234}));
    cen_mode = 1;
    wait_ok("rd3000");
    check_dout("rd3000", 24'h003000);

    // write to the tagged word
    cen_mode = 0;
    snap();
    pulse_wr(24'h003000, 16'h0077, 2'b01);
    apply_write(24'h003000, 16'h0077, 2'b01);
`ifdef JT900H_RAMSRV_WRFWD_EN
    for (int g = 0; g < NI; g++)
      check($sformatf("fwd_now_i%0d", g), 64'(ram_dout[g]), 64'h5577);
`endif
    wait_ok("wr3000");
    check_dout("wr3000", 24'h003000);
    for (int g = 0; g < NI; g++) begin
`ifdef JT900H_RAMSRV_WRFWD_EN
      check($sformatf("wr3000_rd_i%0d", g), 64'(rd_cnt[g] - snap_rd[g]), 64'd0);
`else
      check($sformatf("wr3000_rd_i%0d", g), 64'(rd_cnt[g] - snap_rd[g]), 64'(2 * (WAITS[g] + 1)));
`endif
      check($sformatf("wr3000_lo_i%0d", g), 64'(wr_lo_cnt[g] - snap_lo[g]), 64'(WAITS[g] + 1));
      check($sformatf("wr3000_hi_i%0d", g), 64'(wr_hi_cnt[g] - snap_hi[g]), 64'd0);
    end

    // top word: no carry past 24 bits
    ram_addr = 24'hFFFFFE;
    wait_ok("rdtop");
    check_dout("rdtop", 24'hFFFFFE);
    pulse_wr(24'hFFFFFF, 16'hBEEF, 2'b11);
    apply_write(24'hFFFFFF, 16'hBEEF, 2'b11);
    wait_ok("wrtop");
    check_dout("wrtop", 24'hFFFFFE);
    for (int g = 0; g < NI; g++)
      check($sformatf("wrtop_addr_i%0d", g), 64'(wr_last_addr[g]), 64'hFFFFFF);

    // odd-lane-only write
    snap();
    pulse_wr(24'h002001, 16'hAB00, 2'b10);
    apply_write(24'h002001, 16'hAB00, 2'b10);
    wait_ok("wr2001");
    check_dout("wr2001", 24'h002001);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("wr2001_lo_i%0d", g), 64'(wr_lo_cnt[g] - snap_lo[g]), 64'd0);
      check($sformatf("wr2001_hi_i%0d", g), 64'(wr_hi_cnt[g] - snap_hi[g]), 64'(WAITS[g] + 1));
      check($sformatf("wr2001_addr_i%0d", g), 64'(wr_last_addr[g]), 64'h002001);
      check($sformatf("wr2001_m1_i%0d", g), 64'(mem_rd(g, 24'h002001)), 64'hAB);
      check($sformatf("wr2001_m0_i%0d", g), 64'(mem_rd(g, 24'h002000)), 64'(def_byte(24'h002000)));
    end

    // randomized reads/writes over a few words, random cen
    cen_mode = 1;
    for (int i = 0; i < 60; i++) begin
      a = {23'h002400 + 23'($urandom_range(0, 5)), 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        m = 2'($urandom_range(1, 3));
        pulse_wr(a, d, m);
        apply_write(a, d, m);
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          a1 = {23'h002400 + 23'($urandom_range(0, 5)), 1'b0};
          ram_addr = a1;
          tick(); tick();
        end
        ram_addr = a;
      end
      wait_ok($sformatf("rnd%0d", i));
      check_dout($sformatf("rnd%0d", i), a);
    end
    for (int g = 0; g < NI; g++)
      check($sformatf("no_err_i%0d", g), 64'(wr_err[g]), 64'd0);

    // back-to-back writes: second is dropped
    cen_mode = 0;
    pulse_wr(24'h004000, 16'h1111, 2'b11);
    apply_write(24'h004000, 16'h1111, 2'b11);
    pulse_wr(24'h004002, 16'h2222, 2'b11);
    ram_addr = 24'h004000;
    wait_ok("drop_a");
    check_dout("drop_a", 24'h004000);
    ram_addr = 24'h004002;
    wait_ok("drop_b");
    check_dout("drop_b", 24'h004002);
    for (int g = 0; g < NI; g++)
      check($sformatf("wr_err_i%0d", g), 64'(wr_err[g]), 64'd1);

    // reset during the high-byte read phase of the WAIT=0 instance
    ram_addr = 24'h005000;
    tick(); tick();
    check("rst_in_rdhi", 64'({ext_cs[0], ext_we[0], ext_addr[0]}), 64'({1'b1, 1'b0, 24'h005001}));
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      check($sformatf("rst_async_i%0d", g),
            64'({ram_dout[g], ram_ok[g], ext_addr[g], ext_dout[g], ext_cs[g], ext_we[g], wr_err[g]}), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < NI; g++)
      check($sformatf("rst_ok_low_i%0d", g), 64'(ram_ok[g]), 64'd0);
    wait_ok("rst_rd");
    check_dout("rst_rd", 24'h005000);
    for (int g = 0; g < NI; g++)
      check($sformatf("rst_rd_lat_i%0d", g), 64'(lat[g]), 64'(2 * (WAITS[g] + 1) + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
